// File: rtl/axi_pkg.sv
// Shared AXI response codes and FSM state encodings for the AXI slave memory.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/sdp_ram_bwe.sv
// Simple dual-port RAM, 64-bit words, per-byte write enable, registered read.
// A read and write to the same word in one cycle returns the old contents.
module sdp_ram_bwe #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wbe,
  input  logic [63:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [63:0]       rdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave backed by a 64-bit word memory; INCR bursts only, independent
// read and write channels, SLVERR when the write beat count disagrees with awlen.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned ADDR_LSB  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [29:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  w_state_e         w_state_q, w_state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d;
  logic [8:0]       w_cnt_q, w_cnt_d;

  r_state_e         r_state_q, r_state_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [8:0]       r_rem_q, r_rem_d;
  logic             ram_v_q, ram_v_d;
  logic             ram_last_q, ram_last_d;

  logic             ram_we, ram_re;
  logic [63:0]      ram_rdata;
  logic             r_advance;
  logic             addr_unused;

  assign addr_unused = ^{s_axi_awaddr, s_axi_araddr};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    ram_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_idx_d   = s_axi_awaddr[ADDR_LSB +: IDX_W];
          w_len_d   = s_axi_awlen;
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          ram_we  = !rst;
          w_idx_d = w_idx_q + IDX_W'(1);
          if (w_cnt_q != '1) w_cnt_d = w_cnt_q + 9'd1;
          if (s_axi_wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (w_cnt_q == {1'b0, w_len_q}) ? RESP_OKAY : RESP_SLVERR;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Two-stage read pipe (RAM register, output register); the RAM stage only
  // refills when the output can move, so a stalled beat never gets overwritten.
  assign r_advance = !rvalid_q || s_axi_rready;
  assign ram_re    = (r_state_q == R_DATA) && (r_rem_q != '0) && (!ram_v_q || r_advance);

  always_comb begin
    r_state_d  = r_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    r_idx_d    = r_idx_q;
    r_rem_d    = r_rem_q;
    ram_v_d    = ram_v_q;
    ram_last_d = ram_last_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          r_idx_d   = s_axi_araddr[ADDR_LSB +: IDX_W];
          r_rem_d   = {1'b0, s_axi_arlen} + 9'd1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (ram_re) begin
          r_idx_d    = r_idx_q + IDX_W'(1);
          r_rem_d    = r_rem_q - 9'd1;
          ram_last_d = (r_rem_q == 9'd1);
          ram_v_d    = 1'b1;
        end else if (r_advance) begin
          ram_v_d = 1'b0;
        end
        if (r_advance) begin
          rvalid_d = ram_v_q;
          rlast_d  = ram_v_q && ram_last_q;
          if (ram_v_q) rdata_d = ram_rdata;
        end
        if (rvalid_q && s_axi_rready && rlast_q) begin
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      w_idx_q    <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      r_idx_q    <= '0;
      r_rem_q    <= '0;
      ram_v_q    <= 1'b0;
      ram_last_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      w_idx_q    <= w_idx_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      r_idx_q    <= r_idx_d;
      r_rem_q    <= r_rem_d;
      ram_v_q    <= ram_v_d;
      ram_last_q <= ram_last_d;
    end
  end

  sdp_ram_bwe #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_idx_q),
    .wbe   (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (ram_re),
    .raddr (r_idx_q),
    .rdata (ram_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, response codes, wrap,
// read backpressure and mid-burst reset.
module tb_axi_slave_mem;

  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned TMO       = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [29:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] wbuf [16];
  logic [63:0] ebuf [16];

  always #5 clk = ~clk;

  axi_slave_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_LSB  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_handshake(input string tag, input logic [29:0] addr, input logic [7:0] len);
    int unsigned t;
    awaddr = addr; awlen = len; awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin tick(); t++; end
    check({tag, "_aw_timeout"}, 64'(t < TMO), 64'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input string tag, input logic [63:0] data, input logic [7:0] strb, input bit last);
    int unsigned t;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    t = 0;
    while (!wready && t < TMO) begin tick(); t++; end
    check({tag, "_w_timeout"}, 64'(t < TMO), 64'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write_burst(input string tag, input logic [29:0] addr, input logic [7:0] len,
                             input int unsigned nbeats, input logic [7:0] strb,
                             input logic [1:0] exp_resp);
    int unsigned t;
    aw_handshake(tag, addr, len);
    for (int unsigned i = 0; i < nbeats; i++) w_beat(tag, wbuf[i], strb, i == nbeats - 1);
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < TMO) begin tick(); t++; end
    check({tag, "_b_timeout"}, 64'(t < TMO), 64'd1);
    check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_clr"}, 64'(bvalid), 64'd0);
    check({tag, "_awready_back"}, 64'(awready), 64'd1);
  endtask

  task automatic read_burst(input string tag, input logic [29:0] addr, input logic [7:0] len,
                            input bit toggle);
    int unsigned t, beat, cyc;
    araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
    t = 0;
    while (!arready && t < TMO) begin tick(); t++; end
    check({tag, "_ar_timeout"}, 64'(t < TMO), 64'd1);
    tick();
    arvalid = 1'b0;
    tick();
    check({tag, "_lat1"}, 64'(rvalid), 64'd0);
    tick();
    check({tag, "_lat2"}, 64'(rvalid), 64'd1);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      if (!toggle) check({tag, "_gap"}, 64'(rvalid), 64'd1);
      if (rvalid) begin
        check({tag, $sformatf("_data%0d", beat)}, rdata, ebuf[beat]);
        check({tag, $sformatf("_last%0d", beat)}, 64'(rlast), 64'(beat == int'(len)));
        check({tag, "_rresp"}, 64'(rresp), 64'd0);
      end
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid && rready) beat++;
      tick();
      cyc++;
    end
    rready = 1'b0;
    check({tag, "_beats"}, 64'(beat), 64'(int'(len) + 1));
    check({tag, "_rvalid_end"}, 64'(rvalid), 64'd0);
    check({tag, "_arready_back"}, 64'(arready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

    tick();
    tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_rdata",   rdata,        64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // Basic 4-beat write/read
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    write_burst("wr4", 30'h100, 8'd3, 4, 8'hFF, 2'b00);
    ebuf[0] = 64'h11; ebuf[1] = 64'h22; ebuf[2] = 64'h33; ebuf[3] = 64'h44;
    read_burst("rd4", 30'h100, 8'd3, 1'b0);

    // Early wlast: one beat for a two-beat burst
    wbuf[0] = 64'hDEAD_BEEF;
    write_burst("short", 30'h200, 8'd1, 1, 8'hFF, 2'b10);

    // Byte strobes
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst("ones", 30'h300, 8'd0, 1, 8'hFF, 2'b00);
    wbuf[0] = 64'h0;
    write_burst("strb0f", 30'h300, 8'd0, 1, 8'h0F, 2'b00);
    ebuf[0] = 64'hFFFF_FFFF_0000_0000;
    read_burst("rd_strb", 30'h300, 8'd0, 1'b0);
    wbuf[0] = 64'h1234;
    write_burst("strb00", 30'h300, 8'd0, 1, 8'h00, 2'b00);
    read_burst("rd_strb00", 30'h300, 8'd0, 1'b0);

    // 8-beat read under rready backpressure
    for (int unsigned i = 0; i < 8; i++) begin
      wbuf[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 16'h0101);
      ebuf[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 16'h0101);
    end
    write_burst("wr8", 30'h400, 8'd7, 8, 8'hFF, 2'b00);
    read_burst("rd8_bp", 30'h400, 8'd7, 1'b1);

    // Wrap from the last word to word 0; upper address bits ignored
    wbuf[0] = 64'hAAAA_0000_0000_0001; wbuf[1] = 64'hBBBB_0000_0000_0002;
    write_burst("wrap", 30'((MEM_DEPTH - 1) * 8), 8'd1, 2, 8'hFF, 2'b00);
    ebuf[0] = 64'hAAAA_0000_0000_0001; ebuf[1] = 64'hBBBB_0000_0000_0002;
    read_burst("rd_wrap", 30'((MEM_DEPTH - 1) * 8), 8'd1, 1'b0);
    ebuf[0] = 64'hBBBB_0000_0000_0002;
    read_burst("rd_word0", 30'h0, 8'd0, 1'b0);
    read_burst("rd_alias", 30'(MEM_DEPTH * 8), 8'd0, 1'b0);

    // Reset during beat 2 of a 4-beat write
    aw_handshake("rstmid", 30'h500, 8'd3);
    w_beat("rstmid", 64'h5555_0000_0000_0001, 8'hFF, 1'b0);
    wdata = 64'h5555_0000_0000_0002; wstrb = 8'hFF; wvalid = 1'b1; rst = 1'b1;
    tick();
    check("rstmid_bvalid",  64'(bvalid),  64'd0);
    check("rstmid_wready",  64'(wready),  64'd0);
    check("rstmid_awready", 64'(awready), 64'd0);
    wvalid = 1'b0; rst = 1'b0;
    tick();
    check("rstmid_awready_rel", 64'(awready), 64'd1);
    check("rstmid_arready_rel", 64'(arready), 64'd1);
    ebuf[0] = 64'h5555_0000_0000_0001;
    read_burst("rd_after_rst", 30'h500, 8'd0, 1'b0);
    ebuf[0] = 64'h11;
    read_burst("rd_kept", 30'h100, 8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
